// File: rtl/queue_pkg.sv
// Shared types and header-field constants for the queue read path.
// Used by queue_reader and its optional skid buffer.
package queue_pkg;

  localparam int QWIDTH   = 14;
  localparam int LEN_LSB  = 0;
  localparam int LEN_BITS = 4;

  typedef enum logic {
    HDR  = 1'b0,
    BODY = 1'b1
  } state_t;

  typedef struct packed {
    logic [QWIDTH-1:0] data;
    logic              first;
    logic              last;
  } qword_t;

endpackage

// File: rtl/queue_reader_skid.sv
// Two-entry valid/ready skid buffer between the framing FSM and m_*.
// Slot 0 is always the head; o_occ is registered so the pop path has no m_ready dependency.
module queue_reader_skid
  import queue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_flush,
  input  logic       i_valid,
  input  qword_t     i_word,
  input  logic       i_ready,
  output logic       o_valid,
  output qword_t     o_word,
  output logic [1:0] o_occ
);

  qword_t     r_slot0;
  qword_t     r_slot1;
  logic [1:0] r_occ;
  logic       w_deq;
  logic [1:0] w_after;

  assign w_deq   = (r_occ != 2'd0) && i_ready;
  assign w_after = r_occ - {1'b0, w_deq};

  assign o_valid = (r_occ != 2'd0);
  assign o_word  = r_slot0;
  assign o_occ   = r_occ;

  // Dequeue from slot 0, shift slot 1 forward, write incoming word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ   <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
    end else if (i_flush) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= w_after + {1'b0, i_valid};
      if (w_deq && (r_occ == 2'd2)) begin
        r_slot0 <= r_slot1;
      end
      if (i_valid) begin
        if (w_after == 2'd0) begin
          r_slot0 <= i_word;
        end else begin
          r_slot1 <= i_word;
        end
      end
    end
  end

endmodule

// File: rtl/queue_reader.sv
// Pops a FWFT queue, frames header/length messages, streams them on m_*.
// Define QUEUE_READER_SKID_EN for a 2-entry skid buffer that decouples pop from m_ready.
module queue_reader #(
  parameter int WIDTH    = queue_pkg::QWIDTH,
  parameter int LEN_LSB  = queue_pkg::LEN_LSB,
  parameter int LEN_BITS = queue_pkg::LEN_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q_dout,
  input  logic             q_empty,
  output logic             q_rd_en,
  input  logic             flush,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_first,
  output logic             m_last,
  output logic             busy
);

  import queue_pkg::*;

  state_t              r_state;
  state_t              w_nstate;
  logic [LEN_BITS-1:0] r_count;
  logic [LEN_BITS-1:0] w_ncount;
  logic [LEN_BITS-1:0] w_len;
  logic                w_pop;
  logic                w_room;
  qword_t              w_word;

  assign w_len   = q_dout[LEN_LSB +: LEN_BITS];
  assign w_pop   = rst_n && !q_empty && !flush && w_room;
  assign q_rd_en = w_pop;
  assign busy    = (r_state == BODY);

  // Framing state and remaining payload count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HDR;
      r_count <= '0;
    end else begin
      r_state <= w_nstate;
      r_count <= w_ncount;
    end
  end

  // Next state/count and the first/last tags for the head entry.
  always_comb begin
    w_nstate     = r_state;
    w_ncount     = r_count;
    w_word.data  = q_dout;
    w_word.first = 1'b0;
    w_word.last  = 1'b0;
    unique case (r_state)
      HDR: begin
        w_word.first = 1'b1;
        w_word.last  = (w_len == '0);
        if (w_pop) begin
          w_ncount = w_len;
          w_nstate = (w_len == '0) ? HDR : BODY;
        end
      end
      BODY: begin
        w_word.last = (r_count == LEN_BITS'(1));
        if (w_pop) begin
          w_ncount = r_count - 1'b1;
          if (r_count == LEN_BITS'(1)) begin
            w_nstate = HDR;
          end
        end
      end
      default: begin
        w_nstate = HDR;
      end
    endcase
    if (flush) begin
      w_nstate = HDR;
      w_ncount = '0;
    end
  end

`ifdef QUEUE_READER_SKID_EN

  logic [1:0] w_occ;
  logic       w_skid_valid;
  qword_t     w_skid_word;

  assign w_room = (w_occ != 2'd2);

  queue_reader_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (w_pop),
    .i_word  (w_word),
    .i_ready (m_ready),
    .o_valid (w_skid_valid),
    .o_word  (w_skid_word),
    .o_occ   (w_occ)
  );

  assign m_valid = w_skid_valid;
  assign m_data  = w_skid_word.data;
  assign m_first = w_skid_word.first;
  assign m_last  = w_skid_word.last;

`else

  qword_t r_word;
  logic   r_valid;

  assign w_room  = !r_valid || m_ready;
  assign m_valid = r_valid;
  assign m_data  = r_word.data;
  assign m_first = r_word.first;
  assign m_last  = r_word.last;

  // Single output register: load on pop, drain on accept, drop on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_word  <= w_word;
    end else if (m_ready) begin
      r_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_queue_reader.sv
// Scoreboard bench for queue_reader with a behavioural FWFT queue model.
// Expected words are queued by the stimulus; a monitor checks each handshake.
module tb_queue_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] q_dout = '0;
  logic        q_empty = 1'b1;
  logic        q_rd_en;
  logic        flush = 1'b0;
  logic [13:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_first;
  logic        m_last;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_busy   = 0;
  int n_val    = 0;

`ifdef QUEUE_READER_SKID_EN
  localparam int STALL_POPS = 1;
`else
  localparam int STALL_POPS = 0;
`endif

  typedef struct packed {
    logic [13:0] d;
    logic        f;
    logic        l;
  } exp_t;

  logic [13:0] model[$];
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  queue_reader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_dout  (q_dout),
    .q_empty (q_empty),
    .q_rd_en (q_rd_en),
    .flush   (flush),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_first (m_first),
    .m_last  (m_last),
    .busy    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_w(input logic [13:0] d, input logic f,
                          input logic l);
    exp_t e;
    e.d = d;
    e.f = f;
    e.l = l;
    exp_q.push_back(e);
  endtask

  // One cycle: drive at negedge, sample pop decision #1 later.
  task automatic step(input logic rdy, input logic fl, input logic rst);
    @(negedge clk);
    rst_n   = rst;
    m_ready = rdy;
    flush   = fl;
    q_empty = (model.size() == 0);
    q_dout  = q_empty ? 14'h3fff : model[0];
    #1;
    if (q_empty) chk("pop_on_empty", {31'd0, q_rd_en}, 32'd0);
    if (q_rd_en && model.size() != 0) begin
      void'(model.pop_front());
      n_rd++;
    end
    if (busy) n_busy++;
    if (m_valid) n_val++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || model.size() != 0) && k < 40) begin
      step(1'b1, 1'b0, 1'b1);
      k++;
    end
    chk("drain_timeout", {31'd0, k < 40}, 32'd1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
  endtask

  task automatic clr();
    n_rd   = 0;
    n_busy = 0;
    n_val  = 0;
  endtask

  // Monitor: hold checks and scoreboard compare on every handshake.
  initial begin
    logic        pv, pr, pf, prst;
    logic [15:0] pw;
    exp_t        e;
    pv = 0; pr = 0; pf = 0; prst = 0; pw = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && prst && !pf && pv && !pr) begin
        chk("hold", {15'd0, m_valid, m_data, m_first, m_last},
            {15'd0, 1'b1, pw});
      end
      if (rst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, m_data, m_first, m_last}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("word", {16'd0, m_data, m_first, m_last},
              {16'd0, e.d, e.f, e.l});
        end
      end
      pv   = m_valid;
      pr   = m_ready;
      pf   = flush;
      prst = rst_n;
      pw   = {m_data, m_first, m_last};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    q_empty = 1'b0;
    q_dout  = 14'h2003;
    #1;
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {18'd0, m_data}, 32'd0);
    chk("rst_first", {31'd0, m_first}, 32'd0);
    chk("rst_last", {31'd0, m_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, q_rd_en}, 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);

    // Zero-length header.
    clr();
    model.push_back(14'h0000);
    expect_w(14'h0000, 1'b1, 1'b1);
    drain();
    chk("t1_rd", n_rd, 1);
    chk("t1_busy", n_busy, 0);
    chk("t1_valid_cycles", n_val, 1);

    // Header + 3 payloads, streaming.
    clr();
    model = '{14'h2003, 14'h0011, 14'h0022, 14'h0033};
    expect_w(14'h2003, 1'b1, 1'b0);
    expect_w(14'h0011, 1'b0, 1'b0);
    expect_w(14'h0022, 1'b0, 1'b0);
    expect_w(14'h0033, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    chk("t2_rd_consec", n_rd, 4);
    drain();
    chk("t2_rd", n_rd, 4);
    chk("t2_busy", n_busy, 3);
    chk("t2_valid_cycles", n_val, 4);

    // Stall after the header word.
    clr();
    model = '{14'h2003, 14'h0011, 14'h0022, 14'h0033};
    expect_w(14'h2003, 1'b1, 1'b0);
    expect_w(14'h0011, 1'b0, 1'b0);
    expect_w(14'h0022, 1'b0, 1'b0);
    expect_w(14'h0033, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    n_rd = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    chk("t3_stall_rd", n_rd, STALL_POPS);
    chk("t3_hold_data", {18'd0, m_data}, 32'h2003);
    chk("t3_hold_first", {31'd0, m_first}, 32'd1);
    drain();

    // Empty queue gap mid-message.
    clr();
    model = '{14'h2003, 14'h0011};
    expect_w(14'h2003, 1'b1, 1'b0);
    expect_w(14'h0011, 1'b0, 1'b0);
    expect_w(14'h0022, 1'b0, 1'b0);
    expect_w(14'h0033, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("t4_gap_busy", {31'd0, busy}, 32'd1);
      if (i > 0) chk("t4_gap_valid", {31'd0, m_valid}, 32'd0);
    end
    model.push_back(14'h0022);
    model.push_back(14'h0033);
    drain();

    // Asynchronous reset in BODY with count=2.
    clr();
    model = '{14'h0003, 14'h0101, 14'h0202, 14'h0303};
    expect_w(14'h0003, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("t5_pre_busy", {31'd0, busy}, 32'd1);
    step(1'b1, 1'b0, 1'b0);
    chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_rd_en", {31'd0, q_rd_en}, 32'd0);
    model.delete();
    step(1'b1, 1'b0, 1'b1);
    model = '{14'h0001, 14'h0155};
    expect_w(14'h0001, 1'b1, 1'b0);
    expect_w(14'h0155, 1'b0, 1'b1);
    drain();

    // Flush during BODY: leftovers parse as headers.
    clr();
    model = '{14'h0003, 14'h0111, 14'h0140, 14'h0230};
    expect_w(14'h0003, 1'b1, 1'b0);
    expect_w(14'h0111, 1'b0, 1'b0);
    expect_w(14'h0140, 1'b1, 1'b1);
    expect_w(14'h0230, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    n_rd = 0;
    step(1'b1, 1'b1, 1'b1);
    chk("t6_flush_rd", n_rd, 0);
    step(1'b1, 1'b0, 1'b1);
    chk("t6_flush_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_flush_busy", {31'd0, busy}, 32'd0);
    drain();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
